// File: rtl/mem_port_arbiter_pkg.sv
// Shared cpu package: word width, NOP data word, arbiter FSM states and the
// latched memory command.
package mem_port_arbiter_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;
  localparam word_t NOP_WORD = '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arbState_e;

  typedef struct packed {
    logic  we;
    word_t addr;
    word_t wdata;
  } memCmd_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and unified-memory bus signals of the port arbiter.
interface mem_port_if;
  import mem_port_arbiter_pkg::*;

  logic  if_req_i;
  word_t if_addr_i;
  word_t if_rdata_o;
  logic  if_ready_o;
  logic  dm_req_i;
  logic  dm_we_i;
  word_t dm_addr_i;
  word_t dm_wdata_i;
  word_t dm_rdata_o;
  logic  dm_ready_o;
  logic  mem_req_o;
  logic  mem_we_o;
  word_t mem_addr_o;
  word_t mem_wdata_o;
  word_t mem_rdata_i;
  logic  mem_ack_i;
  logic  stall_o;
  logic  err_o;

  // Arbiter side.
  modport slave (
    input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_rdata_i, mem_ack_i,
    output if_rdata_o, if_ready_o, dm_rdata_o, dm_ready_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, err_o
  );

  // Requesters plus memory side.
  modport master (
    output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_rdata_i, mem_ack_i,
    input  if_rdata_o, if_ready_o, dm_rdata_o, dm_ready_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, err_o
  );
endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Busy-cycle watchdog: expired is high in the BUSY cycle that completes
// TIMEOUT cycles without an ack.
module mem_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (en && !expired)  cnt <= cnt + CW'(1);
  end

  assign expired = en && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter in front of a unified single-port memory, with
// fetch-starvation guard and a busy watchdog that aborts hung accesses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 4
) (
  input logic      clk_i,
  input logic      rst_i,
  mem_port_if.slave bus
);
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  arbState_e     state, stateNxt;
  memCmd_t       cmd;
  logic [SW-1:0] starveCnt;
  logic          grantIf, grantDm, ackSeen, timedOut;
  logic          busy, starveHit, wdExpired;
  logic          ifReady, dmReady, err;
  word_t         ifRdata, dmRdata;

  assign busy      = (state != IDLE);
  assign starveHit = (STARVE_MAX > 0) && (starveCnt == SW'(STARVE_MAX)) && bus.if_req_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= stateNxt;
  end

  // No grant while a ready pulse is out: the requester still holds its request.
  always_comb begin
    stateNxt = state;
    grantIf  = 1'b0;
    grantDm  = 1'b0;
    ackSeen  = 1'b0;
    timedOut = 1'b0;
    case (state)
      IDLE: begin
        if (!(ifReady || dmReady)) begin
          if (bus.dm_req_i && !starveHit) begin
            grantDm  = 1'b1;
            stateNxt = BUSY_DM;
          end else if (bus.if_req_i) begin
            grantIf  = 1'b1;
            stateNxt = BUSY_IF;
          end
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (bus.mem_ack_i) begin
          ackSeen  = 1'b1;
          stateNxt = IDLE;
        end else if (wdExpired) begin
          timedOut = 1'b1;
          stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  mem_watchdog #(.TIMEOUT(TIMEOUT)) uWatchdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (grantIf | grantDm),
    .en      (busy & ~bus.mem_ack_i),
    .expired (wdExpired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmd       <= '0;
      starveCnt <= '0;
      ifReady   <= 1'b0;
      dmReady   <= 1'b0;
      ifRdata   <= NOP_WORD;
      dmRdata   <= NOP_WORD;
      err       <= 1'b0;
    end else begin
      ifReady <= 1'b0;
      dmReady <= 1'b0;
      if (grantDm) begin
        cmd <= '{we: bus.dm_we_i, addr: bus.dm_addr_i, wdata: bus.dm_wdata_i};
        if (bus.if_req_i && (starveCnt != SW'(STARVE_MAX)))
          starveCnt <= starveCnt + SW'(1);
      end
      if (grantIf) begin
        cmd       <= '{we: 1'b0, addr: bus.if_addr_i, wdata: NOP_WORD};
        starveCnt <= '0;
      end
      // Aborted accesses and writes complete with a zero data word.
      if (ackSeen || timedOut) begin
        if (state == BUSY_IF) begin
          ifReady <= 1'b1;
          ifRdata <= ackSeen ? bus.mem_rdata_i : NOP_WORD;
        end else begin
          dmReady <= 1'b1;
          dmRdata <= (ackSeen && !cmd.we) ? bus.mem_rdata_i : NOP_WORD;
        end
      end
      if (timedOut) err <= 1'b1;
    end
  end

  assign bus.mem_req_o   = busy;
  assign bus.mem_we_o    = busy & cmd.we;
  assign bus.mem_addr_o  = cmd.addr;
  assign bus.mem_wdata_o = cmd.wdata;
  assign bus.if_ready_o  = ifReady;
  assign bus.if_rdata_o  = ifRdata;
  assign bus.dm_ready_o  = dmReady;
  assign bus.dm_rdata_o  = dmRdata;
  assign bus.err_o       = err;
  assign bus.stall_o     = (bus.if_req_i & ~ifReady) | (bus.dm_req_i & ~dmReady);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grants and completions are
// queued when requests are issued and popped when the DUT produces them.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int TIMEOUT    = 4;
  localparam int STARVE_MAX = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_if bus();

  mem_port_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  memCmd_t grantQ[$];
  word_t   ifExpQ[$];
  word_t   dmExpQ[$];
  int nChecks = 0, nErrs = 0;
  int cyc = 0;
  int ackLat = 0;
  bit strayAck = 1'b0;
  int busyCnt = 0, lastBusyLen = 0, lastGrantCyc = 0, lastGap = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic word_t memWord(input word_t a);
    return (a == 32'h40) ? 32'h0050_0093 : (a ^ 32'h5A5A_0000);
  endfunction

  function automatic memCmd_t mkCmd(input logic we, input word_t a, input word_t wd);
    memCmd_t c;
    c.we = we; c.addr = a; c.wdata = wd;
    return c;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model and grant checker.
  initial begin
    memCmd_t g;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = 32'hBAD0_BAD0;
      if (bus.mem_req_o) begin
        busyCnt++;
        if (busyCnt == 1) begin
          lastGap      = cyc - lastGrantCyc;
          lastGrantCyc = cyc;
          if (grantQ.size() == 0) chk("grant_queue", 32'(grantQ.size()), 1);
          else begin
            g = grantQ.pop_front();
            chk("grant_addr", bus.mem_addr_o, g.addr);
            chk("grant_we", 32'(bus.mem_we_o), 32'(g.we));
            chk("grant_wdata", bus.mem_wdata_o, g.wdata);
          end
        end
        if (busyCnt == ackLat + 1) begin
          bus.mem_ack_i   = 1'b1;
          bus.mem_rdata_i = memWord(bus.mem_addr_o);
        end
      end else begin
        if (busyCnt != 0) lastBusyLen = busyCnt;
        busyCnt = 0;
        if (strayAck) begin
          bus.mem_ack_i   = 1'b1;
          bus.mem_rdata_i = 32'h1234_5678;
        end
      end
    end
  end

  // Completion checker plus stall relation.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.if_ready_o) begin
        if (ifExpQ.size() == 0) chk("if_ready_queue", 32'(ifExpQ.size()), 1);
        else chk("if_rdata", bus.if_rdata_o, ifExpQ.pop_front());
      end
      if (bus.dm_ready_o) begin
        if (dmExpQ.size() == 0) chk("dm_ready_queue", 32'(dmExpQ.size()), 1);
        else chk("dm_rdata", bus.dm_rdata_o, dmExpQ.pop_front());
      end
      chk("stall", 32'(bus.stall_o),
          32'((bus.if_req_i & ~bus.if_ready_o) | (bus.dm_req_i & ~bus.dm_ready_o)));
    end
  end

  task automatic request(input bit isIf, input logic we, input word_t a, input word_t wd,
                         input bit expTimeout, output int lat);
    int start;
    bit done;
    if (isIf) begin
      ifExpQ.push_back(expTimeout ? NOP_WORD : memWord(a));
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = a;
    end else begin
      dmExpQ.push_back((expTimeout || we) ? NOP_WORD : memWord(a));
      bus.dm_req_i   = 1'b1;
      bus.dm_we_i    = we;
      bus.dm_addr_i  = a;
      bus.dm_wdata_i = wd;
    end
    start = cyc;
    done  = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk); #1;
      done = isIf ? bus.if_ready_o : bus.dm_ready_o;
    end
    if (!done) chk(isIf ? "if_ready_wait" : "dm_ready_wait", 32'(done), 1);
    lat = cyc - start;
    if (isIf) bus.if_req_i = 1'b0;
    else      bus.dm_req_i = 1'b0;
  endtask

  task automatic idleCycle();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    int lat, lat1, lat2, d1, d2, d3;
    bus.if_req_i = 1'b0; bus.if_addr_i = '0;
    bus.dm_req_i = 1'b0; bus.dm_we_i = 1'b0; bus.dm_addr_i = '0; bus.dm_wdata_i = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(bus.mem_req_o), 0);
    chk("rst_mem_we", 32'(bus.mem_we_o), 0);
    chk("rst_mem_addr", bus.mem_addr_o, 0);
    chk("rst_if_ready", 32'(bus.if_ready_o), 0);
    chk("rst_dm_ready", 32'(bus.dm_ready_o), 0);
    chk("rst_err", 32'(bus.err_o), 0);
    rst = 1'b0;
    idleCycle();

    // Single fetch, ack two cycles into BUSY.
    ackLat = 2;
    grantQ.push_back(mkCmd(1'b0, 32'h40, 32'h0));
    request(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, lat);
    chk("fetch_latency", 32'(lat), 4);
    idleCycle();

    // Minimum latency data read.
    ackLat = 0;
    grantQ.push_back(mkCmd(1'b0, 32'h1000_0024, 32'h0));
    request(1'b0, 1'b0, 32'h1000_0024, 32'h0, 1'b0, lat);
    chk("dm_min_latency", 32'(lat), 2);
    idleCycle();

    // Simultaneous requests: data write first, fetch three cycles later.
    grantQ.push_back(mkCmd(1'b1, 32'h10, 32'hDEAD));
    grantQ.push_back(mkCmd(1'b0, 32'h44, 32'h0));
    fork
      request(1'b0, 1'b1, 32'h10, 32'hDEAD, 1'b0, lat1);
      request(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, lat2);
    join
    chk("simul_dm_latency", 32'(lat1), 2);
    chk("simul_if_latency", 32'(lat2), 5);
    chk("back_to_back_gap", 32'(lastGap), 3);
    idleCycle(); idleCycle();
    chk("if_rdata_hold", bus.if_rdata_o, memWord(32'h44));
    chk("dm_rdata_write", bus.dm_rdata_o, 32'h0);

    // Starvation guard: DM, DM, IF, DM.
    ackLat = 1;
    grantQ.push_back(mkCmd(1'b0, 32'h100, 32'h0));
    grantQ.push_back(mkCmd(1'b0, 32'h104, 32'h0));
    grantQ.push_back(mkCmd(1'b0, 32'h200, 32'h0));
    grantQ.push_back(mkCmd(1'b0, 32'h108, 32'h0));
    fork
      request(1'b1, 1'b0, 32'h200, 32'h0, 1'b0, lat);
      begin
        request(1'b0, 1'b0, 32'h100, 32'h0, 1'b0, d1);
        request(1'b0, 1'b0, 32'h104, 32'h0, 1'b0, d2);
        request(1'b0, 1'b0, 32'h108, 32'h0, 1'b0, d3);
      end
    join
    idleCycle();

    // Ack lands in the same cycle the watchdog would fire.
    ackLat = TIMEOUT - 1;
    grantQ.push_back(mkCmd(1'b0, 32'h300, 32'h0));
    request(1'b0, 1'b0, 32'h300, 32'h0, 1'b0, lat);
    idleCycle();
    chk("collision_busy_len", 32'(lastBusyLen), TIMEOUT);
    chk("collision_err", 32'(bus.err_o), 0);

    // No ack: abort after TIMEOUT busy cycles.
    ackLat = -1;
    grantQ.push_back(mkCmd(1'b0, 32'h80, 32'h0));
    request(1'b0, 1'b0, 32'h80, 32'h0, 1'b1, lat);
    chk("timeout_latency", 32'(lat), TIMEOUT + 1);
    idleCycle();
    chk("timeout_busy_len", 32'(lastBusyLen), TIMEOUT);
    chk("timeout_err", 32'(bus.err_o), 1);
    ackLat = 0;
    grantQ.push_back(mkCmd(1'b0, 32'h48, 32'h0));
    request(1'b1, 1'b0, 32'h48, 32'h0, 1'b0, lat);
    idleCycle();
    chk("err_sticky", 32'(bus.err_o), 1);

    // Stray ack in IDLE.
    strayAck = 1'b1;
    idleCycle(); idleCycle();
    strayAck = 1'b0;
    chk("stray_mem_req", 32'(bus.mem_req_o), 0);
    chk("stray_if_rdata", bus.if_rdata_o, memWord(32'h48));

    // Reset in the middle of a data write; late ack after release.
    ackLat = -1;
    grantQ.push_back(mkCmd(1'b1, 32'h20, 32'hBEEF));
    bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b1; bus.dm_addr_i = 32'h20; bus.dm_wdata_i = 32'hBEEF;
    idleCycle(); idleCycle();
    chk("pre_rst_busy", 32'(bus.mem_req_o), 1);
    chk("pre_rst_we", 32'(bus.mem_we_o), 1);
    rst = 1'b1;
    #1;
    chk("rst_async_mem_req", 32'(bus.mem_req_o), 0);
    chk("rst_async_we", 32'(bus.mem_we_o), 0);
    chk("rst_async_addr", bus.mem_addr_o, 0);
    chk("rst_async_wdata", bus.mem_wdata_o, 0);
    chk("rst_async_if_rdata", bus.if_rdata_o, 0);
    chk("rst_async_err", 32'(bus.err_o), 0);
    chk("rst_stall_follows", 32'(bus.stall_o), 1);
    bus.dm_req_i = 1'b0;
    idleCycle();
    rst = 1'b0;
    idleCycle();
    strayAck = 1'b1;
    idleCycle();
    strayAck = 1'b0;
    idleCycle(); idleCycle();
    chk("post_rst_dm_ready", 32'(bus.dm_ready_o), 0);
    chk("post_rst_mem_req", 32'(bus.mem_req_o), 0);
    chk("post_rst_dm_rdata", bus.dm_rdata_o, 0);
    chk("post_rst_err", 32'(bus.err_o), 0);

    chk("grant_queue_left", 32'(grantQ.size()), 0);
    chk("if_queue_left", 32'(ifExpQ.size()), 0);
    chk("dm_queue_left", 32'(dmExpQ.size()), 0);

    $display("Result: errors=%0d of %0d checks", nErrs, nChecks);
    $finish;
  end
endmodule
